// File: rtl/twiddle_gen_stage.sv
// Radix-2 SDF twiddle generator: a per-sample counter drives a quarter-wave cosine ROM
// through a two-stage pipeline, producing cos/-sin (forward) or cos/+sin (inverse) per sample.
module twiddle_gen_stage #(
    parameter int N     = 256,
    parameter int STAGE = 0,
    parameter int BW    = 14
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 in_sop,
    input  logic                 inverse,
    output logic signed [BW-1:0] tw_re,
    output logic signed [BW-1:0] tw_im,
    output logic                 out_valid,
    output logic                 out_sop
);
    localparam int LOGN = $clog2(N);
    localparam int QN   = N / 4;
    localparam int AW   = LOGN - 1;
    localparam int L    = N >> STAGE;
    localparam int HALF = L / 2;

    // Elaboration-time cosine: Taylor series over [0, pi/2], rounded half away from zero.
    function automatic logic signed [BW-1:0] rom_val(input int i);
        real x, term, sum, v;
        x    = 2.0 * 3.14159265358979323846 * i / N;
        sum  = 1.0;
        term = 1.0;
        for (int n = 1; n <= 12; n++) begin
            term = -term * x * x / ((2 * n - 1) * (2 * n));
            sum  = sum + term;
        end
        v = sum * real'(1 << (BW - 2));
        v = (v >= 0.0) ? v + 0.5 : v - 0.5;
        return BW'($rtoi(v));
    endfunction

    logic signed [BW-1:0] rom [QN+1];
    for (genvar gi = 0; gi <= QN; gi++) begin : g_rom
        assign rom[gi] = rom_val(gi);
    end

    logic [LOGN-1:0] cnt_q, cnt_d, cnt_use, h, k, j;
    logic            mode_q, mode_d, mode_use, take_sop;
    logic [AW-1:0]   a_re_q, a_re_d, a_im_q, a_im_d;
    logic            neg_q, neg_d, inv_q, inv_d;
    logic [1:0]      vld_pipe_q, vld_pipe_d, sop_pipe_q, sop_pipe_d;
    logic signed [BW-1:0] tw_re_q, tw_re_d, tw_im_q, tw_im_d;

    always_comb begin
        take_sop = in_valid && in_sop;
        cnt_use  = take_sop ? '0 : cnt_q;
        mode_use = take_sop ? inverse : mode_q;
        cnt_d    = in_valid ? cnt_use + 1'b1 : cnt_q;
        mode_d   = mode_use;

        // First half of each block uses k=0; second half steps by 2^STAGE.
        h = cnt_use & LOGN'(L - 1);
        k = '0;
        if (h >= LOGN'(HALF))
            k = (h - LOGN'(HALF)) << STAGE;

        j = '0;
        if (k <= LOGN'(QN)) begin
            a_re_d = AW'(k);
            a_im_d = AW'(QN) - AW'(k);
            neg_d  = 1'b0;
        end else begin
            j      = k - LOGN'(QN);
            a_re_d = AW'(QN) - AW'(j);
            a_im_d = AW'(j);
            neg_d  = 1'b1;
        end
        inv_d      = mode_use;
        vld_pipe_d = {vld_pipe_q[0], in_valid};
        sop_pipe_d = {sop_pipe_q[0], take_sop};

        tw_re_d = tw_re_q;
        tw_im_d = tw_im_q;
        if (vld_pipe_q[0]) begin
            tw_re_d = neg_q ? -rom[a_re_q] : rom[a_re_q];
            tw_im_d = inv_q ? rom[a_im_q] : -rom[a_im_q];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            mode_q     <= 1'b0;
            a_re_q     <= '0;
            a_im_q     <= '0;
            neg_q      <= 1'b0;
            inv_q      <= 1'b0;
            vld_pipe_q <= '0;
            sop_pipe_q <= '0;
            tw_re_q    <= '0;
            tw_im_q    <= '0;
        end else begin
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            a_re_q     <= a_re_d;
            a_im_q     <= a_im_d;
            neg_q      <= neg_d;
            inv_q      <= inv_d;
            vld_pipe_q <= vld_pipe_d;
            sop_pipe_q <= sop_pipe_d;
            tw_re_q    <= tw_re_d;
            tw_im_q    <= tw_im_d;
        end
    end

    assign tw_re     = tw_re_q;
    assign tw_im     = tw_im_q;
    assign out_valid = vld_pipe_q[1];
    assign out_sop   = sop_pipe_q[1];
endmodule
